// File: rtl/gpio_button_pkg.sv
// Shared types and 50 MHz timing defaults for the Pano button filter.
package gpio_button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int unsigned CLK_HZ                    = 50_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = CLK_HZ / 100;  // 10 ms
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = CLK_HZ * 2;    // 2 s
    localparam int unsigned HOLD_W                    = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gpio_button_filter.sv
// Debounces the Pano button pad into a clean level plus press, release and long-press pulses.
module gpio_button_filter
    import gpio_button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              button_i,
    output logic              level_o,
    output logic              press_o,
    output logic              release_o,
    output logic              long_press_o,
    output logic [HOLD_W-1:0] held_cycles_o
);

    localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE     = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [HOLD_W-1:0] LONG_LIM    = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic              RELEASED_PAD = ACTIVE_LOW;

    logic sync;
    logic raw_n;

    sync_2ff #(.RESET_VAL(RELEASED_PAD)) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (button_i),
        .q   (sync)
    );

    assign raw_n = ACTIVE_LOW ? ~sync : sync;

    btn_state_t        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [HOLD_W-1:0] hold, hold_nx, hold_inc;
    logic              armed, armed_nx;
    logic              level_nx, press_nx, release_nx, long_nx;

    assign hold_inc      = (hold == '1) ? hold : hold + HOLD_W'(1);
    assign held_cycles_o = hold;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            hold         <= '0;
            armed        <= 1'b1;
            level_o      <= 1'b0;
            press_o      <= 1'b0;
            release_o    <= 1'b0;
            long_press_o <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            hold         <= hold_nx;
            armed        <= armed_nx;
            level_o      <= level_nx;
            press_o      <= press_nx;
            release_o    <= release_nx;
            long_press_o <= long_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_nx   = state;
        cnt_nx     = cnt;
        hold_nx    = hold;
        armed_nx   = armed;
        level_nx   = level_o;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (raw_n) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!raw_n) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_DONE) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                    hold_nx  = '0;
                    level_nx = 1'b1;
                    press_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                hold_nx = hold_inc;
                if (!raw_n) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed keeps hold and armed, so it can never re-fire long press.
                if (raw_n) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                    hold_nx  = hold_inc;
                end else if (cnt == CNT_DONE) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    hold_nx    = '0;
                    armed_nx   = 1'b1;
                    level_nx   = 1'b0;
                    release_nx = 1'b1;
                end else begin
                    cnt_nx  = cnt + CNT_ONE;
                    hold_nx = hold_inc;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Hold is only nonzero-going while pressed, and cleared on release, so long press never collides.
        if (armed && (state == PRESSED || state == RELEASE_WAIT) && hold_nx == LONG_LIM) begin
            long_nx  = 1'b1;
            armed_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_button_filter.sv
// Scoreboard bench for gpio_button_filter: stimulus queues expected pulses, a monitor pops and compares.
module tb_gpio_button_filter;

    typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2} ev_t;
    typedef struct {
        int  unit;
        ev_t kind;
        int  cyc;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_a = 1'b1;
    logic btn_b = 1'b0;

    logic        level_a, press_a, rel_a, long_a;
    logic        level_b, press_b, rel_b, long_b;
    logic [31:0] held_a, held_b;

    int edge_cnt = 0;
    int total = 0;
    int bad = 0;

    gpio_button_filter #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (10),
        .ACTIVE_LOW        (1'b1)
    ) dut_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .button_i      (btn_a),
        .level_o       (level_a),
        .press_o       (press_a),
        .release_o     (rel_a),
        .long_press_o  (long_a),
        .held_cycles_o (held_a)
    );

    gpio_button_filter #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (10),
        .ACTIVE_LOW        (1'b0)
    ) dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .button_i      (btn_b),
        .level_o       (level_b),
        .press_o       (press_b),
        .release_o     (rel_b),
        .long_press_o  (long_b),
        .held_cycles_o (held_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push(input int unit, input ev_t kind, input int cyc);
        exp_t e;
        e.unit = unit;
        e.kind = kind;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic got(input int unit, input ev_t kind);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: unit %0d kind %0d at edge %0d, none expected",
                     unit, int'(kind), edge_cnt);
        end else begin
            e = sb.pop_front();
            check("ev_unit", unit, e.unit);
            check("ev_kind", int'(kind), int'(e.kind));
            check("ev_cycle", edge_cnt, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (press_a) got(0, EV_PRESS);
        if (rel_a)   got(0, EV_RELEASE);
        if (long_a)  got(0, EV_LONG);
        if (press_b) got(1, EV_PRESS);
        if (rel_b)   got(1, EV_RELEASE);
        if (long_b)  got(1, EV_LONG);
    end

    task automatic wait_edge(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    initial begin
        int b;
        int lvl_min;

        repeat (3) @(negedge clk);
        check("rst_level_a", int'(level_a), 0);
        check("rst_pulses_a", int'({press_a, rel_a, long_a}), 0);
        check("rst_held_a", int'(held_a), 0);
        check("rst_level_b", int'(level_b), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press then clean release
        b = edge_cnt + 1;
        btn_a = 1'b0;
        push(0, EV_PRESS, b + 6);
        wait_edge(b + 5);
        check("s1_level_before", int'(level_a), 0);
        wait_edge(b + 6);
        check("s1_level_after", int'(level_a), 1);
        btn_a = 1'b1;
        push(0, EV_RELEASE, b + 13);
        wait_edge(b + 14);
        check("s1_level_released", int'(level_a), 0);
        check("s1_held_cleared", int'(held_a), 0);
        check("s1_sb_empty", sb.size(), 0);

        // Bounce: low 3, high 2, then stable low
        b = edge_cnt + 1;
        btn_a = 1'b0;
        push(0, EV_PRESS, b + 11);
        wait_edge(b + 2);
        btn_a = 1'b1;
        wait_edge(b + 4);
        btn_a = 1'b0;
        wait_edge(b + 10);
        check("s2_level_glitch", int'(level_a), 0);
        wait_edge(b + 11);
        check("s2_level_pressed", int'(level_a), 1);
        btn_a = 1'b1;
        push(0, EV_RELEASE, b + 18);
        wait_edge(b + 20);
        check("s2_level_released", int'(level_a), 0);
        check("s2_sb_empty", sb.size(), 0);

        // Long press: held 30 cycles
        b = edge_cnt + 1;
        btn_a = 1'b0;
        push(0, EV_PRESS, b + 6);
        push(0, EV_LONG, b + 16);
        push(0, EV_RELEASE, b + 36);
        wait_edge(b + 29);
        btn_a = 1'b1;
        wait_edge(b + 30);
        check("s3_held_24", int'(held_a), 24);
        wait_edge(b + 35);
        check("s3_level_before_rel", int'(level_a), 1);
        wait_edge(b + 36);
        check("s3_level_after_rel", int'(level_a), 0);
        check("s3_held_cleared", int'(held_a), 0);
        wait_edge(b + 40);
        check("s3_sb_empty", sb.size(), 0);

        // Release bounce after long press
        b = edge_cnt + 1;
        btn_a = 1'b0;
        push(0, EV_PRESS, b + 6);
        push(0, EV_LONG, b + 16);
        wait_edge(b + 20);
        btn_a = 1'b1;
        wait_edge(b + 22);
        btn_a = 1'b0;
        lvl_min = 1;
        for (int e = b + 23; e <= b + 30; e++) begin
            wait_edge(e);
            if (!level_a) lvl_min = 0;
            if (e == b + 27) check("s4_held_kept", int'(held_a), 21);
        end
        check("s4_level_held", lvl_min, 1);
        btn_a = 1'b1;
        push(0, EV_RELEASE, b + 37);
        wait_edge(b + 40);
        check("s4_level_released", int'(level_a), 0);
        check("s4_sb_empty", sb.size(), 0);

        // Reset mid-PRESS_WAIT with the pad held low
        b = edge_cnt + 1;
        btn_a = 1'b0;
        wait_edge(b + 3);
        rst = 1'b1;
        wait_edge(b + 4);
        check("s5_rst_outputs", int'({level_a, press_a, rel_a, long_a}), 0);
        check("s5_rst_held", int'(held_a), 0);
        rst = 1'b0;
        push(0, EV_PRESS, b + 11);
        wait_edge(b + 10);
        check("s5_level_pending", int'(level_a), 0);
        wait_edge(b + 11);
        check("s5_level_pressed", int'(level_a), 1);
        btn_a = 1'b1;
        push(0, EV_RELEASE, b + 18);
        wait_edge(b + 20);
        check("s5_sb_empty", sb.size(), 0);

        // Active-high polarity
        b = edge_cnt + 1;
        btn_b = 1'b1;
        push(1, EV_PRESS, b + 6);
        wait_edge(b + 5);
        check("s6_level_before", int'(level_b), 0);
        wait_edge(b + 6);
        check("s6_level_after", int'(level_b), 1);
        btn_b = 1'b0;
        push(1, EV_RELEASE, b + 13);
        wait_edge(b + 15);
        check("s6_level_released", int'(level_b), 0);
        check("s6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
